// File: rtl/dual_port_ram_fifo_ctrl_if.sv
// Stream and RAM-port bundle for the dual-port-RAM FIFO controller.
// The slave modport is the controller's view; master is the environment's view.
interface dual_port_ram_fifo_ctrl_if #(
  parameter int unsigned RAMWIDTH     = 8,
  parameter int unsigned RAMSIZEWIDTH = 3
);
  logic                    in_valid;
  logic                    in_ready;
  logic [RAMWIDTH-1:0]     in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [RAMWIDTH-1:0]     out_data;
  logic [RAMSIZEWIDTH+1:0] count;
  logic                    ram_we1;
  logic [RAMSIZEWIDTH-1:0] ram_addr1;
  logic [RAMWIDTH-1:0]     ram_data1;
  logic                    ram_we2;
  logic [RAMSIZEWIDTH-1:0] ram_addr2;
  logic [RAMWIDTH-1:0]     ram_data2;
  logic [RAMWIDTH-1:0]     ram_out2;

  modport slave (
    input  in_valid, in_data, out_ready, ram_out2,
    output in_ready, out_valid, out_data, count,
    output ram_we1, ram_addr1, ram_data1, ram_we2, ram_addr2, ram_data2
  );

  modport master (
    output in_valid, in_data, out_ready, ram_out2,
    input  in_ready, out_valid, out_data, count,
    input  ram_we1, ram_addr1, ram_data1, ram_we2, ram_addr2, ram_data2
  );
endinterface

// File: rtl/dual_port_ram_fifo_ctrl.sv
// FIFO controller around a dual-port RAM with a registered read port; a two-entry
// head/skid output buffer absorbs the read latency so one push and one pop per cycle sustain.
module dual_port_ram_fifo_ctrl #(
  parameter int unsigned RAMWIDTH     = 8,
  parameter int unsigned RAMSIZEWIDTH = 3,
  parameter int unsigned DEPTH        = 8
) (
  input logic                      clk,
  input logic                      rst,
  dual_port_ram_fifo_ctrl_if.slave bus
);
  localparam logic [RAMSIZEWIDTH-1:0] LastPtr   = RAMSIZEWIDTH'(DEPTH - 1);
  localparam logic [RAMSIZEWIDTH-1:0] PtrOne    = RAMSIZEWIDTH'(1);
  localparam logic [RAMSIZEWIDTH:0]   DepthCnt  = (RAMSIZEWIDTH + 1)'(DEPTH);
  localparam logic [RAMSIZEWIDTH:0]   StoredOne = (RAMSIZEWIDTH + 1)'(1);

  logic [RAMSIZEWIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [RAMSIZEWIDTH:0]   stored_q, stored_d;
  logic                    rd_pend_q, rd_pend_d;
  logic [1:0]              occ_q, occ_d, occ_after_pop;
  logic [RAMWIDTH-1:0]     head_q, head_d, skid_q, skid_d;
  logic [2:0]              inflight;
  logic                    push, pop, issue;

  assign bus.in_ready  = !rst && (stored_q < DepthCnt);
  assign push          = bus.in_valid && bus.in_ready;
  assign bus.out_valid = !rst && (occ_q != 2'd0);
  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.out_data  = head_q;
  assign bus.count     = rst ? '0 : ({1'b0, stored_q}
                                     + {{(RAMSIZEWIDTH + 1){1'b0}}, rd_pend_q}
                                     + {{RAMSIZEWIDTH{1'b0}}, occ_q});

  assign bus.ram_we1   = push;
  assign bus.ram_addr1 = wptr_q;
  assign bus.ram_data1 = bus.in_data;
  assign bus.ram_we2   = 1'b0;
  assign bus.ram_addr2 = rptr_q;
  assign bus.ram_data2 = '0;

  // Reads already owed to the buffer plus those held in it may never exceed two.
  assign inflight = {1'b0, occ_q} + {2'b00, rd_pend_q};
  assign issue    = (stored_q != '0) && (inflight < (pop ? 3'd3 : 3'd2));

  always_comb begin
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    stored_d      = stored_q;
    rd_pend_d     = issue;
    head_d        = head_q;
    skid_d        = skid_q;
    occ_after_pop = pop ? occ_q - 2'd1 : occ_q;
    occ_d         = rd_pend_q ? occ_after_pop + 2'd1 : occ_after_pop;

    if (push) wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + PtrOne;
    if (issue) rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + PtrOne;

    if (push && !issue) begin
      stored_d = stored_q + StoredOne;
    end else if (!push && issue) begin
      stored_d = stored_q - StoredOne;
    end

    if (pop && (occ_q == 2'd2)) head_d = skid_q;
    // Returning read data lands in the head only if the head is free after this pop.
    if (rd_pend_q) begin
      if (occ_after_pop == 2'd0) begin
        head_d = bus.ram_out2;
      end else begin
        skid_d = bus.ram_out2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      stored_q  <= '0;
      rd_pend_q <= 1'b0;
      occ_q     <= 2'd0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      stored_q  <= stored_d;
      rd_pend_q <= rd_pend_d;
      occ_q     <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    head_q <= head_d;
    skid_q <= skid_d;
  end
endmodule

// File: doc/dual_port_ram_fifo_ctrl.md
Name: dual_port_ram_fifo_ctrl

Overview:
- Controller that drives a `dual_port_ram` instance as FIFO storage.
- Push side is a valid/ready stream that writes through RAM port 1.
- Pop side is a valid/ready stream fed by reads through RAM port 2.
- Hides the RAM's 1-cycle registered read latency with a 2-entry output buffer, so full 1-push/1-pop-per-cycle throughput holds.
- Sits between producer/consumer datapaths and the existing `dual_port_ram`; RAM ports connect 1:1.

Parameters:
- RAMWIDTH, 8, data width; must match the attached RAM.
- RAMSIZEWIDTH, 3, RAM address width.
- DEPTH, 8, RAM entries used; 2 <= DEPTH <= 2**RAMSIZEWIDTH.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  push request.
- in_ready  out  1  push accepted when in_valid & in_ready.
- in_data  in  RAMWIDTH  push data.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts; pop = out_valid & out_ready.
- out_data  out  RAMWIDTH  head-of-FIFO data.
- count  out  RAMSIZEWIDTH+2  total entries held (RAM + in-flight + output buffer).
- ram_we1  out  1  RAM port 1 write enable.
- ram_addr1  out  RAMSIZEWIDTH  RAM port 1 address (write pointer).
- ram_data1  out  RAMWIDTH  RAM port 1 write data.
- ram_we2  out  1  tied 0.
- ram_addr2  out  RAMSIZEWIDTH  RAM port 2 address (read pointer).
- ram_data2  out  RAMWIDTH  tied 0.
- ram_out2  in  RAMWIDTH  RAM port 2 registered read data.

Behaviour:
- State:
  - wptr, rptr: 0..DEPTH-1, wrap to 0 after DEPTH-1.
  - stored: 0..DEPTH, entries written but not yet read-issued.
  - rd_pend: 1 bit, read issued last cycle.
  - occ: 0..2, output buffer entries in a head/skid pair.
- Reset (rst high at posedge): wptr, rptr, stored, rd_pend, occ all cleared.
  - out_valid=0, count=0, in_ready=0 while rst is high.
  - RAM contents are not cleared.
- Reset mid-operation drops all data, including any in-flight read; the ram_out2 value following reset is ignored.
- Push:
  - in_ready = !rst & (stored < DEPTH).
  - push = in_valid & in_ready.
  - Combinationally drive ram_we1=push, ram_addr1=wptr, ram_data1=in_data.
  - On push, wptr advances.
- Read issue:
  - issue = (stored > 0) & ((occ + rd_pend - pop) < 2).
  - ram_addr2 = rptr, always driven; ram_we2=0.
  - On issue, rptr advances and rd_pend<=1; otherwise rd_pend<=0.
- stored update: stored <= stored + push - issue.
- Load:
  - When rd_pend=1, ram_out2 is loaded into the output buffer at the next posedge.
  - It goes to the head if the buffer is empty after pop; otherwise it goes to the skid.
  - On pop with skid full, skid moves to head the same edge.
- Outputs:
  - out_valid = (occ != 0).
  - out_data = head register.
  - count = stored + rd_pend + occ.
- Latency: a push at edge E0 into an empty FIFO gives read issue in the cycle after E0, RAM data after E1, and out_valid=1 after E2.
- Capacity: DEPTH+2 entries total. in_ready depends only on stored.
- Collision-free: an issued read never targets the address being written.
  - A read requires stored>0, so rptr != wptr unless stored=DEPTH.
  - At stored=DEPTH no write occurs.
- Full with simultaneous issue: in_ready stays 0 that cycle (registered stored); it reasserts next cycle.
- Empty: out_valid=0. out_data holds its last value; its content is don't-care.
- Backpressure: out_ready=0 holds out_data/out_valid stable. At most 2 reads are outstanding into the buffer.
- Order: strict FIFO across wrap-around.

Test Plan:
- Reset, then push 0x11 once with out_ready=1 -> out_valid rises exactly 3 edges after accept; out_data=0x11; count returns to 0 after pop.
- out_ready=0, push 0x01..0x0A continuously (DEPTH=8) -> in_ready drops after 10 accepts; count=10; ram_we1 never asserted while in_ready=0.
- From full, out_ready=1 -> pops 0x01..0x0A in order, one per cycle; out_valid falls after 0x0A; count=0.
- Continuous push 0..29 with out_ready=1 -> output stream 0..29 in order at 1 per cycle after fill latency; pointers wrap ≥3 times; ram_addr1 never equals ram_addr2 on a write cycle with an issue.
- out_ready toggling 1010… with continuous pushes of incrementing data -> no loss or duplication; out_data stable while out_valid=1 & out_ready=0.
- Push 5 entries, assert rst one cycle mid-stream with a read in flight -> next cycle out_valid=0, count=0; subsequent push 0xAA pops as 0xAA first.
